// File: rtl/leaf_out_arbiter_pkg.sv
// Shared types and helpers for the leaf output arbiter.
// Holds the arbiter state enum, default widths and the port-tag helper.
package leaf_out_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam int unsigned DEF_PAYLOAD_BITS  = 32;
    localparam int unsigned DEF_NUM_PORT_BITS = 4;
    localparam int unsigned BURST_CNT_BITS    = 8;

    // Tag value carried with a beat from stream idx
    function automatic int unsigned port_tag(input int unsigned base, input int unsigned idx);
        return base + idx;
    endfunction

endpackage

// File: rtl/leaf_rr_pick.sv
// Round-robin first-set search: returns the first requesting stream at or
// above i_rr_ptr, wrapping at NUM_PORTS.
module leaf_rr_pick #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned IDX_BITS  = 1
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [IDX_BITS-1:0]  i_rr_ptr,
    output logic                 o_found_c,
    output logic [IDX_BITS-1:0]  o_pick_c
);

    int unsigned w_idx;

    always_comb begin
        o_found_c = 1'b0;
        o_pick_c  = i_rr_ptr;
        w_idx     = 0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            w_idx = (32'(i_rr_ptr) + k) % NUM_PORTS;
            if (!o_found_c && i_req[IDX_BITS'(w_idx)]) begin
                o_found_c = 1'b1;
                o_pick_c  = IDX_BITS'(w_idx);
            end
        end
    end

endmodule

// File: rtl/leaf_out_arbiter.sv
// Round-robin arbiter merging NUM_PORTS user streams into one registered,
// tagged output toward the leaf interface, with bounded bursts per grant.
module leaf_out_arbiter
    import leaf_out_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_PORTS     = 2,
    parameter  int unsigned PAYLOAD_BITS  = DEF_PAYLOAD_BITS,
    parameter  int unsigned NUM_PORT_BITS = DEF_NUM_PORT_BITS,
    parameter  int unsigned PORT_BASE     = 1,
    parameter  int unsigned MAX_BURST     = 8,
    localparam int unsigned IDX_BITS      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                                  clk_user,
    input  logic                                  resetn,
    input  logic [NUM_PORTS*PAYLOAD_BITS-1:0]     din_user,
    input  logic [NUM_PORTS-1:0]                  vld_user,
    output logic [NUM_PORTS-1:0]                  ack_user,
    output logic [NUM_PORT_BITS+PAYLOAD_BITS-1:0] dout_arb,
    output logic                                  vld_arb,
    input  logic                                  ack_arb,
    output logic [IDX_BITS-1:0]                   grant_idx,
    output logic                                  busy
);

    localparam int unsigned DOUT_BITS = NUM_PORT_BITS + PAYLOAD_BITS;

    arb_state_e                r_state;
    arb_state_e                w_state_nxt;
    logic [IDX_BITS-1:0]       r_rr_ptr;
    logic [IDX_BITS-1:0]       r_grant_idx;
    logic [BURST_CNT_BITS-1:0] r_burst_cnt;
    logic                      r_vld_arb;
    logic [DOUT_BITS-1:0]      r_dout;

    logic                      w_found;
    logic [IDX_BITS-1:0]       w_pick;
    logic                      w_free;
    logic                      w_req_g;
    logic                      w_beat;
    logic                      w_burst_done;
    logic [PAYLOAD_BITS-1:0]   w_payload;
    logic [NUM_PORT_BITS-1:0]  w_tag;

    leaf_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_BITS  (IDX_BITS)
    ) u_pick (
        .i_req     (vld_user),
        .i_rr_ptr  (r_rr_ptr),
        .o_found_c (w_found),
        .o_pick_c  (w_pick)
    );

    // Output register can take a new beat when empty or draining this cycle
    assign w_free       = !r_vld_arb || ack_arb;
    assign w_req_g      = vld_user[r_grant_idx];
    assign w_beat       = (r_state == ST_GRANT) && w_free && w_req_g;
    assign w_burst_done = w_beat &&
                          ((r_burst_cnt + BURST_CNT_BITS'(1)) == BURST_CNT_BITS'(MAX_BURST));
    assign w_tag        = NUM_PORT_BITS'(port_tag(PORT_BASE, 32'(r_grant_idx)));

    always_comb begin
        w_payload = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (r_grant_idx == IDX_BITS'(i)) begin
                w_payload = din_user[i*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
        end
    end

    always_ff @(posedge clk_user or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (w_burst_done || (!w_req_g && w_free)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ack_user = '0;
        busy     = (r_state == ST_GRANT);
        if ((r_state == ST_GRANT) && w_free) begin
            ack_user[r_grant_idx] = 1'b1;
        end
    end

    // Grant bookkeeping and the registered output beat
    always_ff @(posedge clk_user or negedge resetn) begin
        if (!resetn) begin
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
            r_burst_cnt <= '0;
            r_vld_arb   <= 1'b0;
            r_dout      <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_found) begin
                r_grant_idx <= w_pick;
                r_burst_cnt <= '0;
            end else if (w_beat) begin
                r_burst_cnt <= r_burst_cnt + BURST_CNT_BITS'(1);
            end
            if ((r_state == ST_GRANT) && (w_state_nxt == ST_IDLE)) begin
                r_rr_ptr <= (r_grant_idx == IDX_BITS'(NUM_PORTS - 1)) ?
                            '0 : r_grant_idx + IDX_BITS'(1);
            end
            if (w_free) begin
                r_vld_arb <= w_beat;
                if (w_beat) begin
                    r_dout <= {w_tag, w_payload};
                end
            end
        end
    end

    assign dout_arb  = r_dout;
    assign vld_arb   = r_vld_arb;
    assign grant_idx = r_grant_idx;

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Scoreboard bench for leaf_out_arbiter: directed scenarios plus random
// traffic checked against a transaction-level round-robin model.
module tb_leaf_out_arbiter;

    localparam int unsigned NP = 2;
    localparam int unsigned PB = 32;
    localparam int unsigned NB = 4;
    localparam int unsigned MB = 8;
    localparam int unsigned DW = NB + PB;

    logic              clk_user = 1'b0;
    logic              resetn   = 1'b0;
    logic [NP*PB-1:0]  din_user = '0;
    logic [NP-1:0]     vld_user = '0;
    logic [NP-1:0]     ack_user;
    logic [DW-1:0]     dout_arb;
    logic              vld_arb;
    logic              ack_arb  = 1'b0;
    logic [0:0]        grant_idx;
    logic              busy;

    int checks = 0;
    int errors = 0;

    // Stimulus state: beats left, next sequence number and payload base per stream
    int unsigned rem  [NP];
    int unsigned seq  [NP];
    int unsigned base [NP];
    int unsigned vprob = 0;
    int unsigned aprob = 0;

    // Scoreboard and arbitration model state
    logic [DW-1:0] exp_q[$];
    int  m_ptr     = 0;
    int  m_cur     = 0;
    int  exp_pick  = -1;
    int  run       = 0;
    bit  exp_idle  = 0;
    bit  prev_busy = 0;

    leaf_out_arbiter #(
        .NUM_PORTS     (NP),
        .PAYLOAD_BITS  (PB),
        .NUM_PORT_BITS (NB),
        .PORT_BASE     (1),
        .MAX_BURST     (MB)
    ) dut (
        .clk_user  (clk_user),
        .resetn    (resetn),
        .din_user  (din_user),
        .vld_user  (vld_user),
        .ack_user  (ack_user),
        .dout_arb  (dout_arb),
        .vld_arb   (vld_arb),
        .ack_arb   (ack_arb),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    initial forever #5 clk_user = ~clk_user;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int first_req(input logic [NP-1:0] v, input int ptr);
        for (int k = 0; k < NP; k++) begin
            if (v[(ptr + k) % NP]) return (ptr + k) % NP;
        end
        return -1;
    endfunction

    // Driver: new inputs shortly after each rising edge
    initial begin
        for (int i = 0; i < NP; i++) begin
            rem[i] = 0; seq[i] = 0; base[i] = 0;
        end
        forever begin
            @(posedge clk_user);
            #1;
            for (int i = 0; i < NP; i++) begin
                vld_user[i] = (rem[i] > 0) && ($urandom_range(99) < vprob);
                din_user[i*PB +: PB] = PB'(base[i] + seq[i]);
            end
            ack_arb = ($urandom_range(99) < aprob);
        end
    end

    // Monitor: checks handshakes, grant order and the scoreboard every falling edge
    initial forever begin
        logic [NP-1:0] exp_ack;
        logic [DW-1:0] e;
        bit free;
        bit acc_g;
        @(negedge clk_user);
        if (!resetn) begin
            exp_q.delete();
            m_ptr = 0; exp_pick = -1; exp_idle = 0; run = 0; prev_busy = 0;
        end else begin
            free  = !vld_arb || ack_arb;
            acc_g = 0;
            chk("ack_onehot", 64'($countones(ack_user) <= 1), 64'(1));
            chk("sb_occupancy", 64'(exp_q.size()), 64'(vld_arb));
            if (exp_pick >= 0) begin
                chk("grant_busy", 64'(busy), 64'(1));
                chk("grant_idx", 64'(grant_idx), 64'(exp_pick));
                m_cur = exp_pick;
                exp_pick = -1;
            end
            if (exp_idle) begin
                chk("grant_end", 64'(busy), 64'(0));
                exp_idle = 0;
            end
            if (!busy && prev_busy) m_ptr = (m_cur + 1) % NP;
            if (!busy) begin
                run = 0;
                if (|vld_user) exp_pick = first_req(vld_user, m_ptr);
            end
            exp_ack = '0;
            if (busy && free) exp_ack[m_cur] = 1'b1;
            chk("ack_user", 64'(ack_user), 64'(exp_ack));
            if (vld_arb && ack_arb) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("dout", 64'(dout_arb), 64'(e));
                end
            end
            for (int i = 0; i < NP; i++) begin
                if (vld_user[i] && ack_user[i]) begin
                    exp_q.push_back({NB'(1 + i), din_user[i*PB +: PB]});
                    seq[i]++;
                    if (rem[i] > 0) rem[i]--;
                    if (busy && i == m_cur) begin
                        run++;
                        acc_g = 1;
                    end
                end
            end
            if (busy && ((acc_g && run == MB) || (!vld_user[m_cur] && free))) exp_idle = 1;
            prev_busy = busy;
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_vld_arb"}, 64'(vld_arb), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_ack_user"}, 64'(ack_user), 64'(0));
        chk({tag, "_grant_idx"}, 64'(grant_idx), 64'(0));
        chk({tag, "_dout"}, 64'(dout_arb), 64'(0));
    endtask

    task automatic do_reset();
        @(posedge clk_user);
        #3;
        resetn = 1'b0;
        for (int i = 0; i < NP; i++) rem[i] = 0;
        #1;
        check_reset_vals("reset");
        repeat (2) @(posedge clk_user);
        #3;
        resetn = 1'b1;
    endtask

    // Wait (bounded) until vld_arb (sel=0) or busy (sel=1) is seen high at a falling edge
    task automatic wait_hi(input string name, input int sel, output bit ok);
        ok = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk_user);
            if ((sel == 0 && vld_arb) || (sel == 1 && busy)) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk({name, "_timeout"}, 64'(0), 64'(1));
    endtask

    initial begin
        bit ok;
        bit exp_v;
        do_reset();

        // Single stream: three beats, one IDLE cycle then one-cycle latency
        @(negedge clk_user);
        #1;
        seq[0] = 0; base[0] = 32'hA0; rem[0] = 3; rem[1] = 0;
        vprob = 100; aprob = 100;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk_user);
            exp_v = (n >= 2 && n <= 4);
            chk("single_vld", 64'(vld_arb), 64'(exp_v));
            if (exp_v) chk("single_dout", 64'(dout_arb), {28'd0, NB'(1), PB'(32'hA0 + n - 2)});
        end

        // Both streams saturating: 8 beats each, one gap cycle between grants
        do_reset();
        @(negedge clk_user);
        #1;
        seq[0] = 0; seq[1] = 0; base[0] = 32'h100; base[1] = 32'h200;
        rem[0] = 1000; rem[1] = 1000;
        wait_hi("burst_start", 0, ok);
        if (ok) begin
            for (int k = 0; k < 27; k++) begin
                if (k > 0) @(negedge clk_user);
                exp_v = (k % 9) != 8;
                chk("burst_vld", 64'(vld_arb), 64'(exp_v));
                if (exp_v) chk("burst_tag", 64'(dout_arb[DW-1 -: NB]), 64'(((k / 9) % 2) ? 2 : 1));
            end
        end
        rem[0] = 0; rem[1] = 0;
        repeat (4) @(negedge clk_user);

        // Reset while a stalled beat is pending, then stream 0 wins first
        aprob = 0; rem[0] = 20; rem[1] = 20;
        wait_hi("stall_beat", 0, ok);
        @(posedge clk_user);
        #3;
        resetn = 1'b0;
        #1;
        check_reset_vals("midreset");
        aprob = 100;
        repeat (2) @(posedge clk_user);
        #3;
        resetn = 1'b1;
        wait_hi("post_reset_grant", 1, ok);
        if (ok) chk("post_reset_idx", 64'(grant_idx), 64'(0));

        // Random traffic with random backpressure
        base[0] = 32'h1000_0000; base[1] = 32'h2000_0000;
        rem[0] = 100000; rem[1] = 100000;
        vprob = 70; aprob = 60;
        repeat (10000) @(posedge clk_user);
        rem[0] = 0; rem[1] = 0; aprob = 100;
        repeat (20) @(negedge clk_user);
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
        chk("drain_vld", 64'(vld_arb), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/leaf_out_arbiter.md
LEAF_OUT_ARBITER -- requirements
Module: leaf_out_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 2: number of user output streams sharing one interface input channel.
REQ-002 Parameter PAYLOAD_BITS, default 32: payload width per stream.
REQ-003 Parameter NUM_PORT_BITS, default 4: width of port tag prepended to payload.
REQ-004 Parameter PORT_BASE, default 1: tag value of stream 0; stream i is tagged PORT_BASE+i.
REQ-005 Parameter MAX_BURST, default 8: maximum beats granted to one stream before rotation; range 1..255.
REQ-006 clk_user  input  1  sole clock; all state on rising edge.
REQ-007 resetn  input  1  asynchronous, active-low reset.
REQ-008 din_user  input  NUM_PORTS*PAYLOAD_BITS  concatenated stream payloads, stream 0 in LSBs.
REQ-009 vld_user  input  NUM_PORTS  per-stream valid.
REQ-010 ack_user  output  NUM_PORTS  per-stream accept; beat transfers when vld_user[i]&&ack_user[i].
REQ-011 dout_arb  output  NUM_PORT_BITS+PAYLOAD_BITS  registered {tag, payload} toward leaf interface.
REQ-012 vld_arb  output  1  dout_arb valid.
REQ-013 ack_arb  input  1  interface accepts dout_arb when vld_arb&&ack_arb.
REQ-014 grant_idx  output  clog2(NUM_PORTS) (min 1)  currently/last granted stream.
REQ-015 busy  output  1  high while in GRANT.

Function
REQ-016 States: IDLE, GRANT; encoding is implementation choice.
REQ-017 Output register "free" = !vld_arb || ack_arb; ack_user[i] = (state==GRANT) && (grant_idx==i) && free; all other ack_user bits 0.
REQ-018 At most one ack_user bit high in any cycle.
REQ-019 IDLE: if any vld_user high, select first requesting stream searching from rr_ptr upward with wrap at NUM_PORTS; load grant_idx, clear burst_cnt, enter GRANT next cycle; no beat accepted in the IDLE cycle.
REQ-020 GRANT: on accepted beat, next cycle vld_arb=1, dout_arb={PORT_BASE+grant_idx, payload}; latency input accept to vld_arb exactly 1 cycle.
REQ-021 GRANT: if free and no beat accepted, vld_arb deasserts next cycle; if !free, dout_arb/vld_arb hold unchanged (no drop, no duplicate).
REQ-022 burst_cnt increments on each accepted beat; width 8 bits.
REQ-023 GRANT -> IDLE when an accepted beat makes burst_cnt reach MAX_BURST, or when vld_user[grant_idx]==0 and free.
REQ-024 On GRANT -> IDLE, rr_ptr = (grant_idx+1) mod NUM_PORTS; otherwise rr_ptr holds.
REQ-025 Other streams' vld_user never preempt an active grant.
REQ-026 Stalled output (ack_arb low) does not count toward burst_cnt and does not end the grant.
REQ-027 NUM_PORTS==1: stream 0 always selected; rotation degenerates to re-grant after IDLE cycle.
REQ-028 busy = (state==GRANT), combinational from state register.

Reset
REQ-029 resetn low asynchronously forces: state=IDLE, rr_ptr=0, grant_idx=0, burst_cnt=0, vld_arb=0, dout_arb=0; ack_user=0 follows.
REQ-030 Reset mid-burst discards any registered, unaccepted dout_arb beat.
REQ-031 Deassertion takes effect at first rising clk_user edge after resetn high; no beat accepted in that cycle.

Structure
REQ-032 Shared package holds: state enum, default PAYLOAD_BITS/NUM_PORT_BITS constants, tag-compose function.
REQ-033 One sub-module natural: leaf_rr_pick (combinational round-robin first-set search from rr_ptr); rest flat.

Verification
REQ-034 Single stream 0 sends 3 beats 0xA0,0xA1,0xA2, ack_arb=1 -> dout_arb = {4'd1,0xA0..0xA2} on consecutive cycles, 1-cycle latency after IDLE cycle.
REQ-035 Both streams continuously valid, MAX_BURST=8, ack_arb=1 -> 8 beats tag 1, one IDLE cycle, 8 beats tag 2, alternating indefinitely.
REQ-036 Stream 1 granted, ack_arb low 5 cycles mid-burst -> dout_arb/vld_arb stable, ack_user=0, burst_cnt unchanged; resumes without loss when ack_arb returns.
REQ-037 Stream 0 drops vld after 2 beats while stream 1 valid -> grant returns IDLE, stream 1 granted next, rr_ptr=1 at transition.
REQ-038 resetn pulsed low while vld_arb=1 with pending beat -> vld_arb=0, busy=0 immediately; after release stream 0 granted first (rr_ptr=0).
REQ-039 Random vld_user/ack_arb 10k cycles -> scoreboard: per-stream order preserved, no loss/duplication, never >1 ack_user, tags correct.
